// File: rtl/buffer_save_reader_if.sv
// buffer_save_reader_if: control, buffer-read and downstream stream signals of the save reader
//   master : reader side (drives busy/done, read requests and the m_* stream)
//   slave  : environment side (drives start, grant, read data and m_ready)
interface buffer_save_reader_if #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512
);
    logic                         start;
    logic [BUFFER_ADDR_WIDTH-1:0] start_addr;
    logic [BUFFER_ADDR_WIDTH:0]   num_lines;
    logic                         busy;
    logic                         done;
    logic                         save_read_addr_valid;
    logic [BUFFER_ADDR_WIDTH-1:0] save_read_addr;
    logic                         save_read_grant;
    logic                         save_read_data_valid;
    logic [BUFFER_DATA_WIDTH-1:0] save_read_data;
    logic                         m_valid;
    logic [BUFFER_DATA_WIDTH-1:0] m_data;
    logic                         m_last;
    logic                         m_ready;
    modport master (
        input  start, start_addr, num_lines, save_read_grant, save_read_data_valid, save_read_data, m_ready,
        output busy, done, save_read_addr_valid, save_read_addr, m_valid, m_data, m_last
    );
    modport slave (
        output start, start_addr, num_lines, save_read_grant, save_read_data_valid, save_read_data, m_ready,
        input  busy, done, save_read_addr_valid, save_read_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/buffer_save_reader.sv
// buffer_save_reader: reads num_lines buffer lines from start_addr and streams them out through a credit-limited FIFO
//   clk, rst            : clock, synchronous active-high reset
//   bus (master)        : start/start_addr/num_lines, busy/done, buffer read request/grant/data, m_* stream
//   perf_stall_cycles   : saturating count of m_valid & !m_ready cycles (only with SAVE_READER_PERF_EN)
module buffer_save_reader #(
    parameter int BUFFER_ADDR_WIDTH = 11,
    parameter int BUFFER_DATA_WIDTH = 512,
    parameter int FIFO_DEPTH        = 8
) (
    input logic clk,
    input logic rst,
    buffer_save_reader_if.master bus
`ifdef SAVE_READER_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles
`endif
);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t                       r_state, w_next;
    logic [BUFFER_ADDR_WIDTH-1:0] r_addr;
    logic [BUFFER_ADDR_WIDTH:0]   r_rem, r_total, r_popped;
    logic [PW:0]                  r_out, r_cnt;
    logic [PW-1:0]                r_wr, r_rd;
    logic [BUFFER_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic                         r_done;
    logic w_start, w_credit, w_accept, w_push, w_pop, w_valid;
    assign w_start  = bus.start && r_state == IDLE;
    // Lines requested but not yet returned plus lines stored can never exceed the FIFO depth,
    // so returned data always has room without backpressure.
    assign w_credit = ({1'b0, r_out} + {1'b0, r_cnt}) < (PW+2)'(FIFO_DEPTH);
    assign w_accept = bus.save_read_addr_valid && bus.save_read_grant;
    // Data with nothing outstanding is stale (e.g. from a transfer aborted by reset).
    assign w_push   = bus.save_read_data_valid && r_out != '0;
    assign w_valid  = r_cnt != '0;
    assign w_pop    = w_valid && bus.m_ready;
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (bus.start) w_next = bus.num_lines == '0 ? DONE : ISSUE;
            ISSUE: if (w_accept && r_rem == (BUFFER_ADDR_WIDTH+1)'(1)) w_next = DRAIN;
            DRAIN: if (w_pop && bus.m_last && r_out == '0) w_next = DONE;
            DONE:  if (r_done) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    always_comb begin
        bus.busy                 = r_state != IDLE;
        bus.done                 = r_done;
        bus.save_read_addr_valid = r_state == ISSUE && w_credit;
        bus.save_read_addr       = r_addr;
        bus.m_valid              = w_valid;
        bus.m_data               = w_valid ? r_mem[r_rd] : '0;
        bus.m_last               = w_valid && r_popped == r_total - 1'b1;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr   <= '0;
            r_rem    <= '0;
            r_total  <= '0;
            r_popped <= '0;
            r_out    <= '0;
            r_cnt    <= '0;
            r_wr     <= '0;
            r_rd     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_addr   <= w_start ? bus.start_addr : w_accept ? r_addr + 1'b1 : r_addr;
            r_rem    <= w_start ? bus.num_lines : w_accept ? r_rem - 1'b1 : r_rem;
            r_total  <= w_start ? bus.num_lines : r_total;
            r_popped <= w_start ? '0 : w_pop ? r_popped + 1'b1 : r_popped;
            r_out    <= r_out + {{PW{1'b0}}, w_accept} - {{PW{1'b0}}, w_push};
            r_cnt    <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
            r_wr     <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd     <= w_pop ? r_rd + 1'b1 : r_rd;
            // done rises on the second DONE cycle, which is also the last one
            r_done   <= r_state == DONE && !r_done;
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= bus.save_read_data;
    end
`ifdef SAVE_READER_PERF_EN
    logic [31:0] r_stall;
    always_ff @(posedge clk) begin
        if (rst || w_start) r_stall <= '0;
        else if (w_valid && !bus.m_ready && r_stall != '1) r_stall <= r_stall + 1'b1;
    end
    assign perf_stall_cycles = r_stall;
`endif
endmodule
